// File: rtl/calc_scheduler.sv
// calc_scheduler
//   Command queue and sequencer sitting between the UART command decoder and
//   the ALU. Parsed commands are buffered in a DEPTH-entry FIFO and issued to
//   the ALU one at a time. Each ALU result is captured and then held on a
//   valid/ready port toward the encoder. Commands that arrive while the queue
//   is full are dropped, and cmd_drop flags each drop.
//
//   Optional feature: define CALC_TIMEOUT_EN to build the ALU watchdog. When
//   the watchdog expires it emits ERR_CODE as the result and pulses
//   timeout_err. Without the macro no counter is built and timeout_err is 0.
//
// Ports
//   clk, n_rst                    clock, synchronous active-low reset
//   parser_done, src1, src2,      incoming command (1-cycle strobe + fields)
//   operator, data_type
//   cmd_drop                      1-cycle pulse: incoming command dropped
//   q_count                       FIFO occupancy
//   busy                          sequencer active or FIFO not empty
//   alu_start, alu_src1/2,        command issue toward the ALU
//   alu_operator, alu_dtype
//   alu_done, alu_res             ALU completion strobe and result
//   res_valid, res_data,          result handshake toward the encoder
//   res_ready
//   timeout_err                   1-cycle pulse on watchdog expiry
//
// State table
//   state  | meaning
//   IDLE   | waiting for a queued command; pops the FIFO head when one is present
//   ISSUE  | alu_start asserted for this single cycle; watchdog reloaded
//   WAIT   | waiting for alu_done (or for watchdog expiry)
//   HOLD   | result presented on res_*; waiting for res_ready

module calc_scheduler #(
    parameter int          DEPTH          = 4,
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [7:0]  ERR_CODE       = 8'hEE
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       parser_done,
    input  logic [7:0]                 src1,
    input  logic [7:0]                 src2,
    input  logic [4:0]                 operator,
    input  logic [3:0]                 data_type,
    output logic                       cmd_drop,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic                       busy,
    output logic                       alu_start,
    output logic [7:0]                 alu_src1,
    output logic [7:0]                 alu_src2,
    output logic [4:0]                 alu_operator,
    output logic [3:0]                 alu_dtype,
    input  logic                       alu_done,
    input  logic [7:0]                 alu_res,
    output logic                       res_valid,
    output logic [7:0]                 res_data,
    input  logic                       res_ready,
    output logic                       timeout_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int CMD_W = 25;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    logic [CMD_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;

    logic             push;
    logic             pop;
    logic             drop;
    logic             wd_expire;
    logic [CMD_W-1:0] head;

    // Push/drop decisions use the occupancy at the start of the cycle, so a
    // command arriving while full is dropped even if a pop happens alongside.
    assign push = parser_done && (count != FULL_CNT);
    assign drop = parser_done && (count == FULL_CNT);
    assign pop  = (state == ST_IDLE) && (count != '0);
    assign head = fifo_mem[rd_ptr];

    assign q_count = count;
    assign busy    = (state != ST_IDLE) || (count != '0);

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (n_rst && push) begin
            fifo_mem[wr_ptr] <= {src1, src2, operator, data_type};
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow is the wrap.
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef CALC_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_cnt;
    logic            timeout_err_q;

    // Down-counter reloaded in ISSUE; it reads zero during the
    // TIMEOUT_CYCLES-th WAIT cycle. alu_done in that same cycle takes priority.
    assign wd_expire = (state == ST_WAIT) && (wd_cnt == '0) && !alu_done;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            wd_cnt        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            timeout_err_q <= wd_expire;
            if (state == ST_ISSUE) begin
                wd_cnt <= WD_W'(TIMEOUT_CYCLES - 1);
            end else if ((state == ST_WAIT) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - WD_W'(1);
            end
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic [31:0] unused_timeout_cycles;

    assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
    assign wd_expire             = 1'b0;
    assign timeout_err           = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state        <= ST_IDLE;
            alu_start    <= 1'b0;
            alu_src1     <= '0;
            alu_src2     <= '0;
            alu_operator <= '0;
            alu_dtype    <= '0;
            res_valid    <= 1'b0;
            res_data     <= '0;
            cmd_drop     <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            cmd_drop  <= drop;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        {alu_src1, alu_src2, alu_operator, alu_dtype} <= head;
                        alu_start <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done) begin
                        res_data  <= alu_res;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else if (wd_expire) begin
                        res_data  <= ERR_CODE;
                        res_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_scheduler.sv
module tb_calc_scheduler;

    logic       clk;
    logic       n_rst;
    logic       parser_done;
    logic [7:0] src1;
    logic [7:0] src2;
    logic [4:0] operator;
    logic [3:0] data_type;
    logic       cmd_drop;
    logic [2:0] q_count;
    logic       busy;
    logic       alu_start;
    logic [7:0] alu_src1;
    logic [7:0] alu_src2;
    logic [4:0] alu_operator;
    logic [3:0] alu_dtype;
    logic       alu_done;
    logic [7:0] alu_res;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic       timeout_err;

    calc_scheduler #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16),
        .ERR_CODE       (8'hEE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .parser_done  (parser_done),
        .src1         (src1),
        .src2         (src2),
        .operator     (operator),
        .data_type    (data_type),
        .cmd_drop     (cmd_drop),
        .q_count      (q_count),
        .busy         (busy),
        .alu_start    (alu_start),
        .alu_src1     (alu_src1),
        .alu_src2     (alu_src2),
        .alu_operator (alu_operator),
        .alu_dtype    (alu_dtype),
        .alu_done     (alu_done),
        .alu_res      (alu_res),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_ready    (res_ready),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q [$];

    // bench-side ALU model and monitors
    int         cyc = 0;
    logic       rdy_en = 1'b0;
    logic       alu_auto = 1'b1;
    int         alu_lat = 2;
    logic       pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_res = 8'h00;
    logic       done_req = 1'b0;
    logic [7:0] done_val = 8'h00;
    int         done_cyc = -10;
    int         rise_cyc = -10;
    logic       prev_rv = 1'b0;
    int         drops = 0;
    int         starts = 0;
    int         errs = 0;
    logic       hs = 1'b0;
    int         last_hs = 0;
    logic       gap_chk = 1'b0;
    logic       gap_pend = 1'b0;

    task automatic tick();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cyc++;
        parser_done = 1'b0;
        alu_done    = 1'b0;
        res_ready   = rdy_en;
        if (cmd_drop) drops++;
        if (timeout_err) errs++;
        if (alu_start) begin
            starts++;
            if (gap_pend) begin
                total++;
                if (cyc != last_hs + 2) begin
                    bad++;
                    $display("FAIL restart_latency: start at %0d, required %0d", cyc, last_hs + 2);
                end
                gap_pend = 1'b0;
            end
        end
        if (res_valid && !prev_rv) rise_cyc = cyc;
        prev_rv = res_valid;
        if (done_req) begin
            alu_done = 1'b1;
            alu_res  = done_val;
            done_cyc = cyc;
            done_req = 1'b0;
        end else if (alu_auto) begin
            if (alu_start) begin
                pend     = 1'b1;
                pend_cnt = alu_lat;
                pend_res = alu_src1 + alu_src2;
            end else if (pend) begin
                if (pend_cnt == 0) begin
                    alu_done = 1'b1;
                    alu_res  = pend_res;
                    done_cyc = cyc;
                    pend     = 1'b0;
                end else begin
                    pend_cnt--;
                end
            end
        end
        hs = 1'b0;
        if (res_valid && res_ready) begin
            hs      = 1'b1;
            last_hs = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL result_unexpected: got %02h, required none", res_data);
            end else begin
                e = exp_q.pop_front();
                if (res_data !== e) begin
                    bad++;
                    $display("FAIL result_order: got %02h, required %02h", res_data, e);
                end
            end
            gap_pend = gap_chk && (q_count != 3'd0);
        end
    endtask

    task automatic do_reset();
        n_rst       = 1'b0;
        parser_done = 1'b0;
        alu_done    = 1'b0;
        tick();
        tick();
        n_rst    = 1'b1;
        pend     = 1'b0;
        done_req = 1'b0;
        gap_pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_cmd(input logic [7:0] a, input logic [7:0] b,
                            input logic [4:0] op, input logic [3:0] dt,
                            input logic accept);
        src1        = a;
        src2        = b;
        operator    = op;
        data_type   = dt;
        parser_done = 1'b1;
        if (accept) exp_q.push_back(8'(a + b));
        tick();
    endtask

    task automatic wait_rv(input string name);
        int n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        total++;
        if (!res_valid) begin
            bad++;
            $display("FAIL %s_wait_valid: res_valid=%0b, required 1", name, res_valid);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        rdy_en = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 400) begin
            tick();
            n++;
        end
        tick();
        total++;
        if (exp_q.size() != 0 || busy) begin
            bad++;
            $display("FAIL %s_drain: left=%0d busy=%0b, required 0/0", name, exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        src1 = 8'h00; src2 = 8'h00; operator = 5'd0; data_type = 4'd0;
        res_ready = 1'b0; alu_res = 8'h00;
        do_reset();
        total++;
        if ({res_valid, alu_start, busy, cmd_drop, timeout_err} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %05b, required 00000",
                     {res_valid, alu_start, busy, cmd_drop, timeout_err});
        end
        total++;
        if ({q_count, alu_src1, alu_src2, alu_operator, alu_dtype, res_data} !== 36'h0) begin
            bad++;
            $display("FAIL reset_data: got %09h, required 0",
                     {q_count, alu_src1, alu_src2, alu_operator, alu_dtype, res_data});
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_auto = 1'b1;
        alu_lat  = 2;
        rdy_en   = 1'b0;
        send_cmd(8'h05, 8'h03, 5'd1, 4'd2, 1'b1);
        total++;
        if (alu_start !== 1'b0 || q_count !== 3'd1) begin
            bad++;
            $display("FAIL single_cycle1: start=%0b q=%0d, required 0/1", alu_start, q_count);
        end
        tick();
        total++;
        if (alu_start !== 1'b1 || alu_src1 !== 8'h05 || alu_src2 !== 8'h03 ||
            alu_operator !== 5'd1 || alu_dtype !== 4'd2) begin
            bad++;
            $display("FAIL single_issue: start=%0b %02h/%02h/%0d/%0d, required 1 05/03/1/2",
                     alu_start, alu_src1, alu_src2, alu_operator, alu_dtype);
        end
        wait_rv("single");
        total++;
        if (rise_cyc != done_cyc + 1 || res_data !== 8'h08) begin
            bad++;
            $display("FAIL single_result: rise=%0d data=%02h, required %0d/08",
                     rise_cyc, res_data, done_cyc + 1);
        end
        repeat (5) tick();
        total++;
        if (res_valid !== 1'b1 || res_data !== 8'h08) begin
            bad++;
            $display("FAIL single_hold: valid=%0b data=%02h, required 1/08", res_valid, res_data);
        end
        drain("single");
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_release: res_valid=%0b, required 0", res_valid);
        end
    endtask

    task automatic test_overflow();
        int d0;
        do_reset();
        rdy_en = 1'b0;
        send_cmd(8'h10, 8'h01, 5'd1, 4'd0, 1'b1);
        wait_rv("overflow");
        d0 = drops;
        for (int i = 0; i < 6; i++) begin
            send_cmd(8'(8'h20 + i), 8'(i * 3), 5'd2, 4'd1, (i < 4));
        end
        tick();
        total++;
        if (q_count !== 3'd4 || drops - d0 != 2) begin
            bad++;
            $display("FAIL overflow_count: q=%0d drops=%0d, required 4/2", q_count, drops - d0);
        end
        drain("overflow");
    endtask

    task automatic test_full_pop();
        int n = 0;
        do_reset();
        rdy_en = 1'b0;
        send_cmd(8'h01, 8'h02, 5'd1, 4'd0, 1'b1);
        wait_rv("fullpop");
        for (int i = 0; i < 4; i++) begin
            send_cmd(8'(8'h40 + i), 8'h11, 5'd3, 4'd0, 1'b1);
        end
        rdy_en = 1'b1;
        hs = 1'b0;
        while (!hs && n < 50) begin
            tick();
            n++;
        end
        rdy_en = 1'b0;
        tick();
        send_cmd(8'hAA, 8'h55, 5'd4, 4'd0, 1'b0);
        total++;
        if (cmd_drop !== 1'b1 || q_count !== 3'd3 || alu_start !== 1'b1) begin
            bad++;
            $display("FAIL full_pop: drop=%0b q=%0d start=%0b, required 1/3/1",
                     cmd_drop, q_count, alu_start);
        end
        drain("fullpop");
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        int         s0;
        logic       ok = 1'b1;
        do_reset();
        rdy_en = 1'b0;
        send_cmd(8'h33, 8'h44, 5'd1, 4'd0, 1'b1);
        wait_rv("bp");
        send_cmd(8'h01, 8'h01, 5'd1, 4'd0, 1'b1);
        send_cmd(8'h02, 8'h02, 5'd1, 4'd0, 1'b1);
        held = res_data;
        s0   = starts;
        repeat (20) begin
            tick();
            if (res_data !== held || res_valid !== 1'b1 || alu_start !== 1'b0 ||
                q_count !== 3'd2) ok = 1'b0;
        end
        total++;
        if (!ok || held !== 8'h77 || starts != s0) begin
            bad++;
            $display("FAIL backpressure: data=%02h ok=%0b starts=%0d, required 77/1/%0d",
                     held, ok, starts, s0);
        end
        drain("bp");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a;
        logic [7:0] b;
        do_reset();
        rdy_en  = 1'b1;
        alu_lat = 1;
        gap_chk = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom_range(255));
            b = 8'($urandom_range(255));
            send_cmd(a, b, 5'(i), 4'(i), 1'b1);
        end
        drain("b2b");
        gap_chk = 1'b0;
        alu_lat = 2;
    endtask

    task automatic test_watchdog();
        int   n = 0;
        logic ok = 1'b1;
        int   e0;
        do_reset();
        alu_auto = 1'b0;
        rdy_en   = 1'b0;
        e0       = errs;
        src1 = 8'h09; src2 = 8'h09; operator = 5'd1; data_type = 4'd0;
        parser_done = 1'b1;
        tick();
        while (!alu_start && n < 20) begin
            tick();
            n++;
        end
`ifdef CALC_TIMEOUT_EN
        exp_q.push_back(8'hEE);
        for (int i = 0; i < 16; i++) begin
            tick();
            if (res_valid !== 1'b0 || timeout_err !== 1'b0) ok = 1'b0;
        end
        tick();
        total++;
        if (!ok || res_valid !== 1'b1 || res_data !== 8'hEE || timeout_err !== 1'b1) begin
            bad++;
            $display("FAIL watchdog_expire: ok=%0b v=%0b d=%02h err=%0b, required 1/1/EE/1",
                     ok, res_valid, res_data, timeout_err);
        end
        done_val = 8'h55;
        done_req = 1'b1;
        tick();
        tick();
        total++;
        if (timeout_err !== 1'b0 || res_data !== 8'hEE || errs - e0 != 1) begin
            bad++;
            $display("FAIL watchdog_late: err=%0b d=%02h errs=%0d, required 0/EE/1",
                     timeout_err, res_data, errs - e0);
        end
        drain("wd");
        // alu_done on the final WAIT cycle wins over expiry
        alu_auto = 1'b1;
        alu_lat  = 15;
        rdy_en   = 1'b0;
        e0       = errs;
        send_cmd(8'h21, 8'h12, 5'd1, 4'd0, 1'b1);
        wait_rv("wd_race");
        total++;
        if (res_data !== 8'h33 || errs != e0) begin
            bad++;
            $display("FAIL watchdog_race: d=%02h errs=%0d, required 33/0", res_data, errs - e0);
        end
        drain("wd_race");
        alu_lat = 2;
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            if (res_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok || errs != e0) begin
            bad++;
            $display("FAIL wait_forever: ok=%0b errs=%0d, required 1/0", ok, errs - e0);
        end
        exp_q.push_back(8'h55);
        done_val = 8'h55;
        done_req = 1'b1;
        wait_rv("wd");
        drain("wd");
`endif
        alu_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_auto = 1'b0;
        rdy_en   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_cmd(8'(i), 8'h10, 5'd1, 4'd0, 1'b1);
        end
        tick();
        total++;
        if (q_count !== 3'd3 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midreset_setup: q=%0d busy=%0b, required 3/1", q_count, busy);
        end
        n_rst = 1'b0;
        tick();
        n_rst = 1'b1;
        exp_q.delete();
        pend = 1'b0;
        total++;
        if ({q_count, busy, res_valid, alu_start, cmd_drop, timeout_err} !== 8'h0 ||
            {alu_src1, alu_src2, alu_operator, alu_dtype, res_data} !== 33'h0) begin
            bad++;
            $display("FAIL midreset_outputs: q=%0d busy=%0b v=%0b src1=%02h, required all 0",
                     q_count, busy, res_valid, alu_src1);
        end
        alu_auto = 1'b1;
        send_cmd(8'h70, 8'h07, 5'd1, 4'd0, 1'b1);
        drain("midreset");
    endtask

    initial begin
        n_rst = 1'b0;
        parser_done = 1'b0;
        alu_done = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_full_pop();
        test_backpressure();
        test_back_to_back();
        test_watchdog();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: cycle=%0d, required completion", cyc);
        $fatal(1);
    end

endmodule
